// File: rtl/serial_bit_feeder.sv
// Parallel-to-serial feeder with a valid/ready word input and a registered serial bit stream.
// Optional SER_PARITY_EN appends an even-parity bit after each word's data bits.
module serial_bit_feeder #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1,
  parameter int GAP       = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             sout,
  output logic             sout_vld,
  output logic             word_done,
  output logic             busy
);

`ifdef SER_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, SHIFT, GAPS} state_t;

  state_t           state, state_n;
  logic [WIDTH-1:0] sreg, sreg_n;
  logic [CW-1:0]    cnt, cnt_n;
  logic [3:0]       gcnt, gcnt_n;
  logic             par_bit, par_bit_n;
  logic             par_phase, par_phase_n;
  logic             sout_n, vld_n, done_n;
  logic             last, hs;

  // last: the bit currently on sout is the final one of the word (parity bit when enabled)
  assign last      = (state == SHIFT) && (cnt == '0) && (!PAR || par_phase);
  assign din_ready = !rst && ((state == IDLE) || ((GAP == 0) && last));
  assign hs        = din_valid && din_ready;
  assign busy      = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      sreg      <= '0;
      cnt       <= '0;
      gcnt      <= '0;
      par_bit   <= 1'b0;
      par_phase <= 1'b0;
      sout      <= 1'b0;
      sout_vld  <= 1'b0;
      word_done <= 1'b0;
    end else begin
      state     <= state_n;
      sreg      <= sreg_n;
      cnt       <= cnt_n;
      gcnt      <= gcnt_n;
      par_bit   <= par_bit_n;
      par_phase <= par_phase_n;
      sout      <= sout_n;
      sout_vld  <= vld_n;
      word_done <= done_n;
    end
  end

  always_comb begin
    state_n     = state;
    sreg_n      = sreg;
    cnt_n       = cnt;
    gcnt_n      = gcnt;
    par_bit_n   = par_bit;
    par_phase_n = par_phase;
    sout_n      = 1'b0;
    vld_n       = 1'b0;
    done_n      = 1'b0;
    // A handshake is only possible in IDLE or on the final bit, so it always means load
    if (hs) begin
      state_n     = SHIFT;
      sout_n      = MSB_FIRST ? din[WIDTH-1] : din[0];
      sreg_n      = MSB_FIRST ? (din << 1) : (din >> 1);
      cnt_n       = CW'(WIDTH - 1);
      vld_n       = 1'b1;
      par_bit_n   = ^din;
      par_phase_n = 1'b0;
    end else begin
      case (state)
        SHIFT: begin
          if (!last) begin
            vld_n = 1'b1;
            if (cnt != '0) begin
              sout_n = MSB_FIRST ? sreg[WIDTH-1] : sreg[0];
              sreg_n = MSB_FIRST ? (sreg << 1) : (sreg >> 1);
              cnt_n  = cnt - 1'b1;
              done_n = (cnt == CW'(1)) && !PAR;
            end else begin
              sout_n      = par_bit;
              par_phase_n = 1'b1;
              done_n      = 1'b1;
            end
          end else if (GAP > 0) begin
            state_n = GAPS;
            gcnt_n  = 4'(GAP);
          end else begin
            state_n = IDLE;
          end
        end
        GAPS: begin
          if (gcnt <= 4'd1) state_n = IDLE;
          else              gcnt_n  = gcnt - 4'd1;
        end
        default: state_n = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_bit_feeder.sv
// Directed bench for serial_bit_feeder: default instance (MSB first, GAP=0) and an
// LSB-first GAP=2 instance; expected bit sequences are hand-written constants.
module tb_serial_bit_feeder;

`ifdef SER_PARITY_EN
  localparam int L = 9;
`else
  localparam int L = 8;
`endif

  // Sequences hold data bits in shift order from bit 8 downward, parity in bit 0
  localparam logic [8:0] SEQ_B0_MSB = 9'b1011_0000_1;
  localparam logic [8:0] SEQ_0D_MSB = 9'b0000_1101_1;
  localparam logic [8:0] SEQ_0D_LSB = 9'b1011_0000_1;
  localparam logic [8:0] SEQ_FF_MSB = 9'b1111_1111_0;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] din_a = '0, din_b = '0;
  logic       valid_a = 1'b0, valid_b = 1'b0;
  logic       ready_a, sout_a, vld_a, done_a, busy_a;
  logic       ready_b, sout_b, vld_b, done_b, busy_b;
  int         passed = 0, total = 0;

  always #5 clk = ~clk;

  serial_bit_feeder #(.WIDTH(8), .MSB_FIRST(1'b1), .GAP(0)) u_dut (
    .clk(clk), .rst(rst), .din(din_a), .din_valid(valid_a), .din_ready(ready_a),
    .sout(sout_a), .sout_vld(vld_a), .word_done(done_a), .busy(busy_a)
  );

  serial_bit_feeder #(.WIDTH(8), .MSB_FIRST(1'b0), .GAP(2)) u_gap (
    .clk(clk), .rst(rst), .din(din_b), .din_valid(valid_b), .din_ready(ready_b),
    .sout(sout_b), .sout_vld(vld_b), .word_done(done_b), .busy(busy_b)
  );

  task automatic test_reset;
    rst = 1'b1; valid_a = 1'b1; din_a = 8'hB0; valid_b = 1'b1; din_b = 8'h0D;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if ({ready_a, sout_a, vld_a, done_a, busy_a} !== 5'b00000)
      $display("FAIL reset_a: got %b want 00000", {ready_a, sout_a, vld_a, done_a, busy_a});
    else passed++;
    total++;
    if ({ready_b, sout_b, vld_b, done_b, busy_b} !== 5'b00000)
      $display("FAIL reset_b: got %b want 00000", {ready_b, sout_b, vld_b, done_b, busy_b});
    else passed++;
    rst = 1'b0; valid_a = 1'b0; valid_b = 1'b0;
    #1;
    total++;
    if ({ready_a, ready_b} !== 2'b11)
      $display("FAIL reset_release_ready: got %b want 11", {ready_a, ready_b});
    else passed++;
  endtask

  task automatic test_single;
    logic [8:0] e;
    e = SEQ_B0_MSB;
    @(posedge clk); #1;
    din_a = 8'hB0; valid_a = 1'b1;
    total++;
    if (ready_a !== 1'b1) $display("FAIL single_ready_idle: got %b want 1", ready_a);
    else passed++;
    @(posedge clk); #1;
    valid_a = 1'b0; din_a = 'x;
    for (int i = 0; i < L; i++) begin
      total++;
      if ({sout_a, vld_a, done_a, busy_a} !== {e[8-i], 1'b1, (i == L-1), 1'b1})
        $display("FAIL single_bit%0d: got %b want %b", i, {sout_a, vld_a, done_a, busy_a},
                 {e[8-i], 1'b1, (i == L-1), 1'b1});
      else passed++;
      @(posedge clk); #1;
    end
    total++;
    if ({sout_a, vld_a, done_a, busy_a, ready_a} !== 5'b00001)
      $display("FAIL single_after: got %b want 00001", {sout_a, vld_a, done_a, busy_a, ready_a});
    else passed++;
    din_a = '0;
  endtask

  task automatic test_back_to_back;
    logic [8:0] e1, e2;
    logic       b;
    e1 = SEQ_B0_MSB; e2 = SEQ_0D_MSB;
    @(posedge clk); #1;
    din_a = 8'hB0; valid_a = 1'b1;
    @(posedge clk); #1;
    din_a = 8'h0D;
    for (int i = 0; i < 2*L; i++) begin
      b = (i < L) ? e1[8-i] : e2[8-(i-L)];
      total++;
      if ({sout_a, vld_a, done_a} !== {b, 1'b1, (i == L-1) || (i == 2*L-1)})
        $display("FAIL b2b_bit%0d: got %b want %b", i, {sout_a, vld_a, done_a},
                 {b, 1'b1, (i == L-1) || (i == 2*L-1)});
      else passed++;
      if (i == 0 || i == L-1) begin
        total++;
        if (ready_a !== (i == L-1))
          $display("FAIL b2b_ready%0d: got %b want %b", i, ready_a, (i == L-1));
        else passed++;
      end
      @(posedge clk); #1;
      if (i == L-1) valid_a = 1'b0;
    end
    total++;
    if ({sout_a, vld_a, done_a, ready_a} !== 4'b0001)
      $display("FAIL b2b_after: got %b want 0001", {sout_a, vld_a, done_a, ready_a});
    else passed++;
  endtask

  task automatic test_gap;
    logic [8:0] e;
    e = SEQ_0D_LSB;
    @(posedge clk); #1;
    din_b = 8'h0D; valid_b = 1'b1;
    @(posedge clk); #1;
    valid_b = 1'b0; din_b = 'x;
    for (int i = 0; i < L; i++) begin
      total++;
      if ({sout_b, vld_b, done_b, ready_b} !== {e[8-i], 1'b1, (i == L-1), 1'b0})
        $display("FAIL gap_bit%0d: got %b want %b", i, {sout_b, vld_b, done_b, ready_b},
                 {e[8-i], 1'b1, (i == L-1), 1'b0});
      else passed++;
      @(posedge clk); #1;
    end
    for (int g = 0; g < 2; g++) begin
      total++;
      if ({sout_b, vld_b, done_b, busy_b, ready_b} !== 5'b00010)
        $display("FAIL gap_idle%0d: got %b want 00010", g, {sout_b, vld_b, done_b, busy_b, ready_b});
      else passed++;
      @(posedge clk); #1;
    end
    total++;
    if ({sout_b, vld_b, busy_b, ready_b} !== 4'b0001)
      $display("FAIL gap_done: got %b want 0001", {sout_b, vld_b, busy_b, ready_b});
    else passed++;
    din_b = '0;
  endtask

  task automatic test_reset_mid;
    logic [8:0] e;
    e = SEQ_FF_MSB;
    @(posedge clk); #1;
    din_a = 8'hFF; valid_a = 1'b1;
    @(posedge clk); #1;
    valid_a = 1'b0;
    for (int i = 0; i < 4; i++) begin
      total++;
      if ({sout_a, vld_a, done_a} !== {e[8-i], 1'b1, 1'b0})
        $display("FAIL rstmid_bit%0d: got %b want %b", i, {sout_a, vld_a, done_a}, {e[8-i], 2'b10});
      else passed++;
      if (i < 3) begin @(posedge clk); #1; end
    end
    rst = 1'b1; valid_a = 1'b1;
    #1;
    total++;
    if (ready_a !== 1'b0) $display("FAIL rstmid_ready: got %b want 0", ready_a);
    else passed++;
    @(posedge clk); #1;
    total++;
    if ({sout_a, vld_a, done_a, busy_a} !== 4'b0000)
      $display("FAIL rstmid_abort: got %b want 0000", {sout_a, vld_a, done_a, busy_a});
    else passed++;
    rst = 1'b0; valid_a = 1'b0;
    test_single();
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_gap();
    test_reset_mid();
    repeat (2) @(posedge clk);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
